mul_unit: RTL
=============

// Module: mul_unit
// PURPOSE
//   Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
//   Sits in the EX stage beside the ALU.
//   - Driven by the controller's mulstart/mulctl.
//   - Operands come from the register file and the B-mux.
//   - done feeds the EX-stage valid (exdone); result feeds the ifuresctl result mux.
// PARAMETERS
//   XLEN  32  operand/result width; must be a power of two >= 4
// PORTS
//   clk     in   1     clock, all state updates on rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     level request; op begins on first IDLE cycle with start=1
//   mulctl  in   2     00 MUL (low, s*s), 01 MULH (high, s*s), 10 MULHSU (high, s*u), 11 MULHU (high, u*u)
//   a       in   XLEN  rs1 operand
//   b       in   XLEN  rs2 operand
//   busy    out  1     high in CALC and FIX states
//   done    out  1     result valid; high in HOLD state only
//   result  out  XLEN  selected half of the 2*XLEN product
// BEHAVIOUR
//   Reset (rst=1 at an edge, from any state): state=IDLE, busy=0, done=0, result=0, internal regs cleared.
//   States and transitions:
//     IDLE -> CALC  when start=1
//       - capture mulctl and |a|, |b| as magnitudes; a is signed unless ctl=11, b is signed only for ctl 00/01
//       - neg = sign(a) XOR sign(b), each sign counted only if that operand is signed
//       - acc (2*XLEN) = 0, cnt = 0
//     CALC -> CALC  each cycle
//       - if mag_b[cnt]: acc += mag_a << cnt
//       - cnt++; exactly XLEN CALC cycles, then -> FIX
//     FIX -> HOLD
//       - product = neg ? -acc : acc (two's complement, 2*XLEN bits)
//       - result = ctl==00 ? product[XLEN-1:0] : product[2*XLEN-1:XLEN]
//       - done=1
//     HOLD -> IDLE  when start=0; done=0, result retained
//       - HOLD persists (done held high) while start=1
//   Latency: start sampled at edge E0; done first high after edge E0+XLEN+2 (34 edges for XLEN=32).
//   Handshake:
//     - start held high through completion never re-triggers; a new op needs start low >=1 cycle.
//     - The controller gates mulstart with EX state.
//   Operands and mulctl are sampled only at the IDLE->CALC edge; changes during CALC/FIX/HOLD ignored.
//   result stable from HOLD until the next FIX; not cleared on leaving HOLD.
//   Width rules:
//     - magnitude of the most negative value (1<<(XLEN-1)) is held as an unsigned XLEN value, no overflow
//     - acc never exceeds 2*XLEN bits; cnt is clog2(XLEN)+1 bits wide
//   Zero operand: full XLEN cycles still taken (fixed latency); result 0, neg of a zero product gives 0.
//   Reset mid-CALC/FIX/HOLD: op abandoned, outputs to reset values next cycle; start high at that time
//     starts a fresh op on the following edge.
// TESTING
//   1 ctl=00, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done rises exactly 34 edges after start sampled
//   2 ctl=01, a=b=0x80000000 -> result 0x40000000
//   3 ctl=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; ctl=11 same operands -> 0xFFFFFFFE
//   4 start held high 100 cycles, a/b toggled during CALC -> single op on captured values, done stays
//     high until start drops, then IDLE
//   5 rst pulsed at CALC cycle 10 -> busy=0, done=0, result=0 next cycle; clean op afterwards correct
//   6 random a,b,ctl (>=1000 ops, incl. 0, 1, -1, INT_MIN) vs $signed/$unsigned 64-bit reference model

Source files
------------

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier for the RV32M multiply
// group (MUL/MULH/MULHSU/MULHU). Operands are converted to magnitudes at
// start, multiplied one bit of b per cycle, and the sign is reapplied in FIX.
module mul_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      mulctl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   // cnt must be able to hold XLEN itself, hence the extra bit.
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   mag_a_q, mag_a_d;
   logic [XLEN-1:0]   mag_b_q, mag_b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [1:0]        ctl_q, ctl_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Operand signedness: a is signed unless MULHU, b only for MUL/MULH.
   logic              a_signed, b_signed;
   logic              a_neg, b_neg;
   logic [2*XLEN-1:0] partial;
   logic [2*XLEN-1:0] product;

   assign a_signed = (mulctl != 2'b11);
   assign b_signed = ~mulctl[1];
   assign a_neg    = a_signed & a[XLEN-1];
   assign b_neg    = b_signed & b[XLEN-1];

   // Shifted multiplicand for the current bit; the most negative value's
   // magnitude fits as an unsigned XLEN value, so no overflow here.
   assign partial  = {{XLEN{1'b0}}, mag_a_q} << cnt_q;
   assign product  = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ctl_q    <= 2'b00;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         ctl_q    <= ctl_d;
         result_q <= result_d;
      end
   end

   // Next-state and datapath update for the IDLE/CALC/FIX/HOLD sequence.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      ctl_d    = ctl_q;
      result_d = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ctl_d   = mulctl;
               mag_a_d = a_neg ? (~a + XLEN'(1)) : a;
               mag_b_d = b_neg ? (~b + XLEN'(1)) : b;
               neg_d   = a_neg ^ b_neg;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // XLEN accumulate steps, then one terminal cycle once cnt
            // reaches XLEN; this yields the fixed XLEN+2 latency.
            if (cnt_q == CW'(XLEN)) begin
               state_d = S_FIX;
            end else begin
               if (mag_b_q[cnt_q[CW-2:0]]) begin
                  acc_d = acc_q + partial;
               end
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FIX: begin
            result_d = (ctl_q == 2'b00) ? product[XLEN-1:0]
                                        : product[2*XLEN-1:XLEN];
            state_d  = S_HOLD;
         end
         S_HOLD: begin
            // Held while start stays high so a level request never re-fires.
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign done   = (state_q == S_HOLD);
   assign result = result_q;

endmodule
